// File: rtl/data_table_delete_pkg.sv
// data_table_delete_pkg: shared hash-table types, widths and result codes
package data_table_delete_pkg;
  localparam int KEY_WIDTH = 16;
  localparam int VALUE_WIDTH = 16;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int BUCKET_WIDTH = 8;
  typedef enum logic [1:0] {OP_INIT, OP_SEARCH, OP_INSERT, OP_DELETE} ht_opcode_t;
  typedef struct packed {
    ht_opcode_t opcode;
    logic [KEY_WIDTH-1:0] key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;
  typedef struct packed {
    ht_command_t cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic head_ptr_val;
  } ht_pdata_t;
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VALUE_WIDTH-1:0] value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic next_ptr_val;
  } ram_data_t;
  typedef enum logic [2:0] {
    SEARCH_FOUND,
    SEARCH_NOT_SUCCESS_NO_ENTRY,
    INSERT_SUCCESS,
    INSERT_SUCCESS_SAME_KEY,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL,
    DELETE_SUCCESS,
    DELETE_NOT_SUCCESS_NO_ENTRY
  } ht_rescode_t;
  typedef enum logic [1:0] {NO_CHAIN, IN_HEAD, IN_MIDDLE, IN_TAIL} ht_chain_state_t;
  typedef struct packed {
    ht_command_t cmd;
    ht_rescode_t rescode;
    ht_chain_state_t chain_state;
  } ht_result_t;
endpackage

// File: rtl/data_table_delete_rd_data_val_helper.sv
// rd_data_val_helper: delays the RAM read strobe by the RAM latency to mark valid read data
module rd_data_val_helper #(
  parameter int RAM_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rd_en_i,
  output logic rd_data_val_o
);
  logic [RAM_LATENCY-1:0] sr;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sr <= '0;
    else sr <= (sr << 1) | RAM_LATENCY'(rd_en_i);
  assign rd_data_val_o = sr[RAM_LATENCY-1];
endmodule

// File: rtl/data_table_delete.sv
// data_table_delete: walks a bucket chain, unlinks and clears the matching entry, frees its address
module data_table_delete
  import data_table_delete_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ht_pdata_t          task_i,
  input  logic               task_valid_i,
  output logic               task_ready_o,
  input  ram_data_t          rd_data_i,
  output logic [A_WIDTH-1:0] rd_addr_o,
  output logic               rd_en_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output ram_data_t          wr_data_o,
  output logic               wr_en_o,
  output logic [A_WIDTH-1:0] empty_addr_o,
  output logic               empty_addr_add_o,
  output logic [A_WIDTH-1:0] head_wr_data_ptr_o,
  output logic               head_wr_data_ptr_val_o,
  output logic               head_wr_en_o,
  output ht_result_t         result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i
);
  typedef enum logic [2:0] {
    IDLE_S, READ_HEAD_S, GO_ON_CHAIN_S, UNLINK_HEAD_S, UNLINK_PREV_S, CLEAR_S, NOT_FOUND_S
  } state_t;
  state_t state, state_d1;
  ht_command_t cmd_locked;
  ht_chain_state_t chain_state;
  ram_data_t prev_data;
  logic [A_WIDTH-1:0] rd_addr, prev_addr, match_next_ptr;
  logic match_next_val, rd_again, rd_data_val, first, key_match;
  rd_data_val_helper #(.RAM_LATENCY(RAM_LATENCY)) val_gen (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en_o), .rd_data_val_o(rd_data_val)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE_S;
      state_d1 <= IDLE_S;
      cmd_locked <= '0;
      chain_state <= NO_CHAIN;
      prev_data <= '0;
      rd_addr <= '0;
      prev_addr <= '0;
      match_next_ptr <= '0;
      match_next_val <= 1'b0;
      rd_again <= 1'b0;
    end else begin
      state_d1 <= state;
      rd_again <= 1'b0;
      case (state)
        IDLE_S:
          if (task_valid_i) begin
            cmd_locked <= task_i.cmd;
            chain_state <= NO_CHAIN;
            rd_addr <= task_i.head_ptr;
            state <= task_i.head_ptr_val ? READ_HEAD_S : NOT_FOUND_S;
          end
        READ_HEAD_S, GO_ON_CHAIN_S:
          if (rd_data_val) begin
            match_next_ptr <= rd_data_i.next_ptr;
            match_next_val <= rd_data_i.next_ptr_val;
            if (key_match) begin
              state <= (state == READ_HEAD_S) ? UNLINK_HEAD_S : UNLINK_PREV_S;
              chain_state <= (state == READ_HEAD_S) ? IN_HEAD :
                             rd_data_i.next_ptr_val ? IN_MIDDLE : IN_TAIL;
            end else if (!rd_data_i.next_ptr_val) begin
              state <= NOT_FOUND_S;
            end else begin
              state <= GO_ON_CHAIN_S;
              prev_addr <= rd_addr;
              prev_data <= rd_data_i;
              rd_addr <= rd_data_i.next_ptr;
              rd_again <= state == GO_ON_CHAIN_S;
            end
          end
        UNLINK_HEAD_S, UNLINK_PREV_S: state <= CLEAR_S;
        CLEAR_S, NOT_FOUND_S: if (result_ready_i) state <= IDLE_S;
        default: state <= IDLE_S;
      endcase
    end
  always_comb begin
    first = state != state_d1;
    key_match = cmd_locked.key == rd_data_i.key;
    task_ready_o = state == IDLE_S;
    rd_addr_o = rd_addr;
    rd_en_o = (state == READ_HEAD_S || state == GO_ON_CHAIN_S) && (first || rd_again);
    wr_en_o = first && (state == UNLINK_PREV_S || state == CLEAR_S);
    wr_addr_o = !wr_en_o ? '0 : (state == UNLINK_PREV_S) ? prev_addr : rd_addr;
    wr_data_o = '0;
    if (wr_en_o && state == UNLINK_PREV_S) begin
      wr_data_o = prev_data;
      wr_data_o.next_ptr = match_next_ptr;
      wr_data_o.next_ptr_val = match_next_val;
    end
    head_wr_en_o = first && state == UNLINK_HEAD_S;
    head_wr_data_ptr_o = head_wr_en_o ? match_next_ptr : '0;
    head_wr_data_ptr_val_o = head_wr_en_o && match_next_val;
    empty_addr_add_o = first && state == CLEAR_S;
    empty_addr_o = empty_addr_add_o ? rd_addr : '0;
    result_valid_o = state == CLEAR_S || state == NOT_FOUND_S;
    result_o = '0;
    if (result_valid_o) begin
      result_o.cmd = cmd_locked;
      result_o.rescode = (state == CLEAR_S) ? DELETE_SUCCESS : DELETE_NOT_SUCCESS_NO_ENTRY;
      result_o.chain_state = chain_state;
    end
  end
endmodule
